// File: rtl/jw_write_arbiter.sv
// jw_write_arbiter: round-robin share of one memory write port among Julia workers; JW_ARB_TIMEOUT_EN abandons writes stuck on mc_busy
module jw_write_arbiter #(
  parameter int NUM_WORKERS = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WORKERS-1:0]        wr_req_i,
  input  logic [NUM_WORKERS*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WORKERS*DATA_W-1:0] wr_data_i,
  output logic [NUM_WORKERS-1:0]        wr_ack_o,
  input  logic                          mc_busy_i,
  output logic                          mc_wr_en_o,
  output logic [ADDR_W-1:0]             mc_addr_o,
  output logic [DATA_W-1:0]             mc_data_o,
  output logic [$clog2(NUM_WORKERS)-1:0] grant_id_o,
  output logic                          arb_busy_o,
  output logic                          mc_timeout_o
);
  localparam int IW = $clog2(NUM_WORKERS);
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, grant_q, grant_d, sel;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic found, wr_en_q, wr_en_d, abort;
  if (NUM_WORKERS < 2 || NUM_WORKERS > 16) begin : g_bad_workers
    $error("NUM_WORKERS must be 2..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
`ifdef JW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q;
  assign abort = state_q == ISSUE && !wr_en_q && mc_busy_i && cnt_q + CW'(1) == CW'(TIMEOUT_CYC);
  // Busy-wait counter is zero outside ISSUE, so it restarts on every ISSUE entry
  always_comb cnt_d = state_q != ISSUE ? '0 : (!wr_en_q && mc_busy_i) ? cnt_q + CW'(1) : cnt_q;
  // Counter and sticky timeout flag (cleared only by reset)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_q | abort;
    end
  assign mc_timeout_o = to_q;
`else
  assign abort        = 1'b0;
  assign mc_timeout_o = 1'b0;
`endif
  // Round-robin search starting just after the last granted worker
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_WORKERS; k++)
      if (!found && wr_req_i[(int'(last_q) + k) % NUM_WORKERS]) begin
        found = 1'b1;
        sel   = IW'((int'(last_q) + k) % NUM_WORKERS);
      end
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // Next state: ISSUE leaves once the strobe has gone out (or the wait was abandoned)
  always_comb
    state_d = state_q == IDLE  ? (found ? ISSUE : IDLE) :
              state_q == ISSUE ? ((wr_en_q || abort) ? ACK : ISSUE) : IDLE;
  // Datapath next values; busy is sampled a cycle ahead so the strobe is a clean register output
  always_comb begin
    grant_d = state_q == IDLE && found ? sel : grant_q;
    addr_d  = state_q == IDLE && found ? wr_addr_i[sel*ADDR_W +: ADDR_W] : addr_q;
    data_d  = state_q == IDLE && found ? wr_data_i[sel*DATA_W +: DATA_W] : data_q;
    wr_en_d = (state_q == IDLE && found) || (state_q == ISSUE && !wr_en_q) ? !mc_busy_i : 1'b0;
    last_d  = state_q == ACK ? grant_q : last_q;
  end
  // Datapath registers; pointer resets so worker 0 wins first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      last_q  <= IW'(NUM_WORKERS - 1);
    end else begin
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      last_q  <= last_d;
    end
  // Moore outputs decoded from state
  always_comb begin
    wr_ack_o   = state_q == ACK ? NUM_WORKERS'(1) << grant_q : '0;
    arb_busy_o = state_q != IDLE;
  end
  assign mc_wr_en_o = wr_en_q;
  assign mc_addr_o  = addr_q;
  assign mc_data_o  = data_q;
  assign grant_id_o = grant_q;
endmodule

// File: doc/jw_write_arbiter.md
Name: jw_write_arbiter

Overview:
- Shares the single memory-controller write port among NUM_WORKERS Julia workers.
- Each worker raises a write request when it has a finished pixel (its done phase).
- The arbiter picks one requester round-robin, latches its address and colour, and issues one write when the memory controller is not busy.
- It then returns a one-cycle acknowledge to that worker, which releases it to take new work from the dispatcher.

Parameters:
- NUM_WORKERS, 4: number of requesting workers, 2..16.
- ADDR_W, 19: pixel address width (640x480 = 307200 fits).
- DATA_W, 8: pixel colour width.
- TIMEOUT_CYC, 255: max cycles waiting on mc_busy. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_req  in  NUM_WORKERS  bit i = worker i has a pixel to write. Held high until its wr_ack.
- wr_addr  in  NUM_WORKERS*ADDR_W  flattened addresses; worker i occupies bits [i*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WORKERS*DATA_W  flattened colours; same packing as wr_addr.
- wr_ack  out  NUM_WORKERS  one-hot, one-cycle pulse: worker's write accepted.
- mc_busy  in  1  memory controller cannot accept a write.
- mc_wr_en  out  1  one-cycle write strobe to memory controller.
- mc_addr  out  ADDR_W  latched address of granted worker.
- mc_data  out  DATA_W  latched colour of granted worker.
- grant_id  out  $clog2(NUM_WORKERS)  index of current/last granted worker.
- arb_busy  out  1  high in every state except IDLE.
- mc_timeout  out  1  sticky timeout flag. Tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - wr_ack = 0, mc_wr_en = 0, mc_addr = 0, mc_data = 0, grant_id = 0, arb_busy = 0, mc_timeout = 0.
  - Round-robin pointer last_grant = NUM_WORKERS-1, so worker 0 has first priority.
- FSM states: IDLE, ISSUE, ACK. All outputs are registered or Moore-decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - If wr_req == 0, stay in IDLE.
  - Otherwise select the first set bit searching last_grant+1, last_grant+2, ..., wrapping modulo NUM_WORKERS.
  - Latch that worker's addr/data into mc_addr/mc_data, set grant_id, go to ISSUE.
- ISSUE:
  - If mc_busy == 0: assert mc_wr_en for exactly this one cycle, then go to ACK.
  - If mc_busy == 1: hold, with mc_wr_en = 0.
  - mc_addr/mc_data are stable for the whole of ISSUE.
- ACK:
  - wr_ack[grant_id] = 1 for one cycle.
  - last_grant <= grant_id.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle 0 -> mc_wr_en in cycle 1 (if not busy) -> wr_ack in cycle 2 -> IDLE in cycle 3. Minimum 3 cycles per write.
- Worker protocol:
  - Worker clears its wr_req on the edge that samples wr_ack, so the next IDLE cycle sees it low.
  - A request held through IDLE after its ack is treated as a new write.
- Boundary conditions:
  - Request dropped after latch: the write still completes and is acked.
  - Request dropped before selection: ignored.
  - Inputs changing during ISSUE/ACK: ignored. Only the latched values are written.
  - All workers requesting continuously: grants rotate 0,1,2,3,0,...; no worker waits more than NUM_WORKERS grants.
  - Single requester: it is granted on every arbitration, regardless of pointer.
  - mc_busy rises in the same cycle as mc_wr_en: the write counts as issued; the controller must accept the strobe.
  - Reset mid-transaction: returns to IDLE immediately. No wr_ack or mc_wr_en is generated for the aborted write; the worker re-requests after reset.

Optional Feature:
- Macro: JW_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ wait counter (sized for TIMEOUT_CYC) clears on entry to ISSUE and increments each ISSUE cycle with mc_busy == 1.
  - When the counter reaches TIMEOUT_CYC, the write is abandoned (no mc_wr_en), FSM goes to ACK, and wr_ack is still pulsed so the worker is not hung.
  - mc_timeout is set and stays high until rst.
- Undefined: no counter; ISSUE waits indefinitely; mc_timeout is constant 0.

Test Plan:
- Reset then single request: wr_req=0001, addr0=0x12345, data0=0xA5, mc_busy=0 -> mc_wr_en cycle 1 with mc_addr=0x12345, mc_data=0xA5; wr_ack=0001 cycle 2; arb_busy low cycle 3.
- Round-robin: wr_req=1111 held, re-raised after each ack -> grant_id sequence 0,1,2,3,0; exactly one mc_wr_en per grant.
- Backpressure: mc_busy=1 for 10 cycles after grant -> mc_wr_en stays 0 and mc_addr holds; mc_wr_en 1 cycle after mc_busy falls, then ack.
- Data change during wait: worker 2 changes wr_data from 0x11 to 0x22 while in ISSUE -> mc_data=0x11 written.
- Reset mid-ISSUE: assert rst during busy wait -> all outputs 0 immediately; next request from worker 1 granted first after worker 0 is idle (pointer reset).
- JW_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mc_busy stuck 1 -> no mc_wr_en; wr_ack after 8 wait cycles; mc_timeout=1 persists until rst.
